rf_arbiter: RTL and testbench

RF_ARBITER -- requirements
Module: rf_arbiter

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rf_arb_rr.sv | 38 +++
 rtl/rf_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the two-port register-file arbiter.
package rf_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage

// File: rtl/rf_arb_rr.sv
// Two-way round-robin picker; the priority pointer moves away from
// whichever requester was last granted.
import rf_arb_pkg::*;

module rf_arb_rr (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic gnt_a_i,
    input  logic gnt_b_i,
    output logic pick_a_o,
    output logic pick_b_o
);

    prio_e prio_q, prio_d;

    assign pick_a_o = req_a_i & (~req_b_i | (prio_q == PRIO_A));
    assign pick_b_o = req_b_i & (~req_a_i | (prio_q == PRIO_B));

    always_comb begin
        prio_d = prio_q;
        if (gnt_a_i) begin
            prio_d = PRIO_B;
        end else if (gnt_b_i) begin
            prio_d = PRIO_A;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto one register-file port, with an
// optional bounded lock that keeps the port owned across grants.
import rf_arb_pkg::*;

module rf_arbiter #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic              WE_A,
    input  logic              WE_B,
    input  logic              LOCK_A,
    input  logic              LOCK_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] WDATA_A,
    input  logic [DATA_W-1:0] WDATA_B,
    output logic              GNT_A,
    output logic              GNT_B,
    output logic              RVALID_A,
    output logic              RVALID_B,
    output logic [DATA_W-1:0] RDATA_A,
    output logic [DATA_W-1:0] RDATA_B,
    output logic              RF_EN,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic [DATA_W-1:0] RF_IN,
    input  logic [DATA_W-1:0] RF_OUT
);

    localparam logic [CNT_W-1:0] LMAX = CNT_W'(LOCK_MAX);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic             pick_a, pick_b;
    logic             gnt_a, gnt_b;
    logic             rd_a, rd_b;

    rf_arb_rr u_rr (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .req_a_i  (REQ_A),
        .req_b_i  (REQ_B),
        .gnt_a_i  (gnt_a),
        .gnt_b_i  (gnt_b),
        .pick_a_o (pick_a),
        .pick_b_o (pick_b)
    );

    // Grants are held low combinationally while reset is asserted.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (RST_N) begin
            unique case (state_q)
                IDLE: begin
                    gnt_a = pick_a;
                    gnt_b = pick_b;
                end
                OWN_A:   gnt_a = REQ_A;
                OWN_B:   gnt_b = REQ_B;
                default: ;
            endcase
        end
    end

    assign rd_a    = gnt_a & ~WE_A;
    assign rd_b    = gnt_b & ~WE_B;
    assign cnt_inc = cnt_q + CNT_W'(1);

    assign GNT_A    = gnt_a;
    assign GNT_B    = gnt_b;
    assign RVALID_A = rvalid_a_q;
    assign RVALID_B = rvalid_b_q;
    assign RDATA_A  = rdata_a_q;
    assign RDATA_B  = rdata_b_q;

    always_comb begin
        RF_EN   = 1'b0;
        RF_ADDR = '0;
        RF_IN   = '0;
        if (gnt_a) begin
            RF_EN   = WE_A;
            RF_ADDR = ADDR_A;
            RF_IN   = WE_A ? WDATA_A : '0;
        end else if (gnt_b) begin
            RF_EN   = WE_B;
            RF_ADDR = ADDR_B;
            RF_IN   = WE_B ? WDATA_B : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            rvalid_a_q <= rd_a;
            rvalid_b_q <= rd_b;
            if (rd_a) rdata_a_q <= RF_OUT;
            if (rd_b) rdata_b_q <= RF_OUT;
            unique case (state_q)
                IDLE: begin
                    // A lock limit of one means the first grant already exhausts it.
                    if (gnt_a && LOCK_A && (LMAX > CNT_W'(1))) begin
                        state_q <= OWN_A;
                        cnt_q   <= CNT_W'(1);
                    end else if (gnt_b && LOCK_B && (LMAX > CNT_W'(1))) begin
                        state_q <= OWN_B;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                OWN_A: begin
                    if (gnt_a) begin
                        if (!LOCK_A || (cnt_inc == LMAX)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else if (!LOCK_A) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                OWN_B: begin
                    if (gnt_b) begin
                        if (!LOCK_B || (cnt_inc == LMAX)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else if (!LOCK_B) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a small behavioural register file.
module tb_rf_arbiter;
    import rf_arb_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_A, REQ_B, WE_A, WE_B, LOCK_A, LOCK_B;
    logic [1:0] ADDR_A, ADDR_B;
    logic [7:0] WDATA_A, WDATA_B;
    logic       GNT_A, GNT_B, RVALID_A, RVALID_B;
    logic [7:0] RDATA_A, RDATA_B;
    logic       RF_EN;
    logic [1:0] RF_ADDR;
    logic [7:0] RF_IN, RF_OUT;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rf [4] = '{default: 8'h00};

    always #5 CLK = ~CLK;

    assign RF_OUT = rf[RF_ADDR];
    always @(posedge CLK) if (RF_EN) rf[RF_ADDR] <= RF_IN;

    rf_arbiter #(.DATA_W(8), .ADDR_W(2), .LOCK_MAX(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .WE_A(WE_A), .WE_B(WE_B),
        .LOCK_A(LOCK_A), .LOCK_B(LOCK_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
        .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .RVALID_A(RVALID_A), .RVALID_B(RVALID_B),
        .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
        .RF_EN(RF_EN), .RF_ADDR(RF_ADDR),
        .RF_IN(RF_IN), .RF_OUT(RF_OUT)
    );

    task automatic clear_inputs();
        REQ_A = 0; REQ_B = 0; WE_A = 0; WE_B = 0; LOCK_A = 0; LOCK_B = 0;
        ADDR_A = 0; ADDR_B = 0; WDATA_A = 0; WDATA_B = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        clear_inputs();
        REQ_A = 1; WE_A = 1; ADDR_A = 3; WDATA_A = 8'hFF;
        REQ_B = 1; ADDR_B = 1;
        @(posedge CLK);
        #1;
        n_cmp++; if (GNT_A !== 1'b0 || GNT_B !== 1'b0) begin n_err++; $display("FAIL rst_gnt got %b%b want 00", GNT_A, GNT_B); end
        n_cmp++; if (RVALID_A !== 1'b0 || RVALID_B !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b%b want 00", RVALID_A, RVALID_B); end
        n_cmp++; if (RF_EN !== 1'b0 || RF_ADDR !== 2'd0 || RF_IN !== 8'h00) begin n_err++; $display("FAIL rst_rf got en=%b a=%0d d=%h want 0/0/00", RF_EN, RF_ADDR, RF_IN); end
        n_cmp++; if (RDATA_A !== 8'h00 || RDATA_B !== 8'h00) begin n_err++; $display("FAIL rst_rdata got %h %h want 00 00", RDATA_A, RDATA_B); end
        n_cmp++; if (dut.state_q !== IDLE || dut.u_rr.prio_q !== PRIO_A || dut.cnt_q !== 8'd0) begin n_err++; $display("FAIL rst_state got st=%0d prio=%0d cnt=%0d want 0/0/0", dut.state_q, dut.u_rr.prio_q, dut.cnt_q); end
        clear_inputs();
        #1 RST_N = 1'b1;
    endtask

    task automatic test_write_read();
        do_reset();
        REQ_A = 1; WE_A = 1; ADDR_A = 2; WDATA_A = 8'h5A;
        @(negedge CLK);
        n_cmp++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin n_err++; $display("FAIL wr_gnt got %b%b want 10", GNT_A, GNT_B); end
        n_cmp++; if (RF_EN !== 1'b1 || RF_ADDR !== 2'd2 || RF_IN !== 8'h5A) begin n_err++; $display("FAIL wr_rf got en=%b a=%0d d=%h want 1/2/5a", RF_EN, RF_ADDR, RF_IN); end
        tick();
        clear_inputs();
        REQ_B = 1; WE_B = 0; ADDR_B = 2;
        @(negedge CLK);
        n_cmp++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0) begin n_err++; $display("FAIL rd_gnt got %b%b want 01", GNT_A, GNT_B); end
        n_cmp++; if (RF_EN !== 1'b0 || RF_ADDR !== 2'd2) begin n_err++; $display("FAIL rd_rf got en=%b a=%0d want 0/2", RF_EN, RF_ADDR); end
        tick();
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if (RVALID_B !== 1'b1 || RDATA_B !== 8'h5A) begin n_err++; $display("FAIL rd_data got v=%b d=%h want 1/5a", RVALID_B, RDATA_B); end
        n_cmp++; if (RF_EN !== 1'b0 || RF_ADDR !== 2'd0 || RF_IN !== 8'h00) begin n_err++; $display("FAIL idle_rf got en=%b a=%0d d=%h want 0/0/00", RF_EN, RF_ADDR, RF_IN); end
        tick();
        @(negedge CLK);
        n_cmp++; if (RVALID_B !== 1'b0 || RDATA_B !== 8'h5A) begin n_err++; $display("FAIL rd_hold got v=%b d=%h want 0/5a", RVALID_B, RDATA_B); end
    endtask

    task automatic test_alternate();
        logic exp_ga, exp_va, exp_vb;
        do_reset();
        REQ_A = 1; WE_A = 1; ADDR_A = 1; WDATA_A = 8'hC3;
        tick();
        do_reset();
        REQ_A = 1; WE_A = 0; ADDR_A = 1;
        REQ_B = 1; WE_B = 0; ADDR_B = 2;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin REQ_A = 0; REQ_B = 0; end
            exp_ga = (i < 4) && (i % 2 == 0);
            exp_va = (i == 1) || (i == 3);
            exp_vb = (i == 2) || (i == 4);
            @(negedge CLK);
            n_cmp++; if (GNT_A !== exp_ga || GNT_B !== ((i < 4) && !exp_ga)) begin n_err++; $display("FAIL alt_gnt[%0d] got %b%b want %b%b", i, GNT_A, GNT_B, exp_ga, (i < 4) && !exp_ga); end
            n_cmp++; if (RVALID_A !== exp_va || RVALID_B !== exp_vb) begin n_err++; $display("FAIL alt_rvalid[%0d] got %b%b want %b%b", i, RVALID_A, RVALID_B, exp_va, exp_vb); end
            if (exp_va) begin n_cmp++; if (RDATA_A !== 8'hC3) begin n_err++; $display("FAIL alt_rdata_a[%0d] got %h want c3", i, RDATA_A); end end
            if (exp_vb) begin n_cmp++; if (RDATA_B !== 8'h5A) begin n_err++; $display("FAIL alt_rdata_b[%0d] got %h want 5a", i, RDATA_B); end end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        REQ_B = 1; WE_B = 0; ADDR_B = 0;
        REQ_A = 1; WE_A = 1; ADDR_A = 3; WDATA_A = 8'h77;
        for (int i = 0; i < 4; i++) begin
            LOCK_A = (i < 3);
            @(negedge CLK);
            n_cmp++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin n_err++; $display("FAIL lock_gnt[%0d] got %b%b want 10", i, GNT_A, GNT_B); end
            if (i > 0) begin
                n_cmp++; if (dut.state_q !== OWN_A) begin n_err++; $display("FAIL lock_state[%0d] got %0d want %0d", i, dut.state_q, OWN_A); end
            end
            tick();
        end
        LOCK_A = 0;
        @(negedge CLK);
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL lock_idle got %0d want %0d", dut.state_q, IDLE); end
        n_cmp++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0) begin n_err++; $display("FAIL lock_then_b got %b%b want 01", GNT_A, GNT_B); end
        tick();
        clear_inputs();
    endtask

    task automatic test_lock_max();
        do_reset();
        REQ_A = 1; WE_A = 0; LOCK_A = 1; ADDR_A = 0;
        REQ_B = 1; WE_B = 0; ADDR_B = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            n_cmp++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin n_err++; $display("FAIL lmax_gnt[%0d] got %b%b want 10", i, GNT_A, GNT_B); end
            if (i > 0) begin
                n_cmp++; if (RVALID_A !== 1'b1) begin n_err++; $display("FAIL lmax_b2b[%0d] got %b want 1", i, RVALID_A); end
            end
            tick();
        end
        @(negedge CLK);
        n_cmp++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0) begin n_err++; $display("FAIL lmax_release got %b%b want 01", GNT_A, GNT_B); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL lmax_state got %0d want %0d", dut.state_q, IDLE); end
        tick();
        @(negedge CLK);
        n_cmp++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin n_err++; $display("FAIL lmax_regrab got %b%b want 10", GNT_A, GNT_B); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ_A = 1; WE_A = 0; LOCK_A = 1; ADDR_A = 2;
        @(negedge CLK);
        n_cmp++; if (GNT_A !== 1'b1) begin n_err++; $display("FAIL mid_gnt got %b want 1", GNT_A); end
        tick();
        @(negedge CLK);
        n_cmp++; if (RVALID_A !== 1'b1 || dut.state_q !== OWN_A) begin n_err++; $display("FAIL mid_own got v=%b st=%0d want 1/%0d", RVALID_A, dut.state_q, OWN_A); end
        RST_N = 1'b0;
        #1;
        n_cmp++; if (GNT_A !== 1'b0 || RVALID_A !== 1'b0 || RDATA_A !== 8'h00) begin n_err++; $display("FAIL mid_rst_a got g=%b v=%b d=%h want 0/0/00", GNT_A, RVALID_A, RDATA_A); end
        n_cmp++; if (RF_EN !== 1'b0 || RF_ADDR !== 2'd0 || RF_IN !== 8'h00) begin n_err++; $display("FAIL mid_rst_rf got en=%b a=%0d d=%h want 0/0/00", RF_EN, RF_ADDR, RF_IN); end
        n_cmp++; if (dut.state_q !== IDLE || dut.cnt_q !== 8'd0) begin n_err++; $display("FAIL mid_rst_state got st=%0d cnt=%0d want 0/0", dut.state_q, dut.cnt_q); end
        tick();
        n_cmp++; if (RVALID_A !== 1'b0) begin n_err++; $display("FAIL mid_no_pulse got %b want 0", RVALID_A); end
        REQ_A = 0; LOCK_A = 0;
        REQ_B = 1; WE_B = 0; ADDR_B = 2;
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0) begin n_err++; $display("FAIL mid_after got %b%b want 01", GNT_A, GNT_B); end
        tick();
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if (RVALID_B !== 1'b1 || RDATA_B !== 8'h5A || RVALID_A !== 1'b0) begin n_err++; $display("FAIL mid_read got vb=%b d=%h va=%b want 1/5a/0", RVALID_B, RDATA_B, RVALID_A); end
        tick();
    endtask

    task automatic test_b_writes();
        logic [7:0] d;
        do_reset();
        REQ_B = 1; WE_B = 1;
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (i + 1));
            ADDR_B = 2'(i); WDATA_B = d;
            @(negedge CLK);
            n_cmp++; if (GNT_B !== 1'b1 || RF_EN !== 1'b1 || RF_ADDR !== 2'(i) || RF_IN !== d) begin n_err++; $display("FAIL bwr[%0d] got g=%b en=%b a=%0d d=%h want 1/1/%0d/%h", i, GNT_B, RF_EN, RF_ADDR, RF_IN, i, d); end
            tick();
        end
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if (RF_EN !== 1'b0 || dut.u_rr.prio_q !== PRIO_A) begin n_err++; $display("FAIL bwr_end got en=%b prio=%0d want 0/0", RF_EN, dut.u_rr.prio_q); end
        n_cmp++; if (rf[3] !== 8'h44 || rf[0] !== 8'h11) begin n_err++; $display("FAIL bwr_rf got %h %h want 11 44", rf[0], rf[3]); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_lock_max();
        test_reset_mid();
        test_b_writes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
